// File: rtl/inv_alu.sv
// MIPS-style ALU slice: combinational result/carry-out plus a registered flag bank.
// Optional XOR on ulaOp 011 is enabled by defining INV_ALU_XOR_EN.
module inv_alu #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ulaOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero_q,
    output logic             carry_q,
    output logic             ovf_q,
    output logic             neg_q
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_XOR  = 3'b011,
        OP_ANDN = 3'b100,
        OP_ORN  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic             v;
    logic             zero_d, carry_d, ovf_d, neg_d;

    assign op = op_e'(ulaOp);

    // One shared adder: SUB and SLT feed ~b, with carry-in !c (borrow) or 1.
    always_comb begin
        b_eff = b;
        cin   = c;
        case (op)
            OP_SUB: begin
                b_eff = ~b;
                cin   = ~c;
            end
            OP_SLT: begin
                b_eff = ~b;
                cin   = 1'b1;
            end
            default: ;
        endcase
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

    always_comb begin
        y    = '0;
        cout = 1'b0;
        v    = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD: begin
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                v    = sum_ovf;
            end
`ifdef INV_ALU_XOR_EN
            OP_XOR:  y = a ^ b;
`else
            OP_XOR:  y = '0;
`endif
            OP_ANDN: y = a & ~b;
            OP_ORN:  y = a | ~b;
            OP_SUB: begin
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                v    = sum_ovf;
            end
            // Signed less-than: sign of the difference corrected by its overflow.
            OP_SLT:  y[0] = sum[WIDTH-1] ^ sum_ovf;
            default: y = '0;
        endcase
    end

    assign zero_d  = (y == '0);
    assign carry_d = cout;
    assign ovf_d   = v;
    assign neg_d   = y[WIDTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: tb/tb_inv_alu.sv
// Scoreboard bench for inv_alu: a 1-bit slice and an 8-bit instance share clock and reset.
module tb_inv_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] op1 = 3'b000, op8 = 3'b000;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       y1, co1, z1, cy1, v1, n1;
    logic [7:0] y8;
    logic       co8, z8, cy8, v8, n8;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         due;
        bit         unit;   // 0: 1-bit slice, 1: 8-bit
        bit         kind;   // 0: y/cout, 1: flags {zero,carry,ovf,neg}
        logic [7:0] y;
        logic       cout;
        logic [3:0] fl;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    inv_alu #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .ulaOp(op1), .a(a1), .b(b1), .c(c1),
        .y(y1), .cout(co1), .zero_q(z1), .carry_q(cy1), .ovf_q(v1), .neg_q(n1)
    );

    inv_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .ulaOp(op8), .a(a8), .b(b8), .c(c8),
        .y(y8), .cout(co8), .zero_q(z8), .carry_q(cy8), .ovf_q(v8), .neg_q(n8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every entry whose due cycle has arrived.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            logic [7:0] gy;
            logic       gc;
            logic [3:0] gf;
            e  = sbq.pop_front();
            gy = e.unit ? y8 : {7'b0, y1};
            gc = e.unit ? co8 : co1;
            gf = e.unit ? {z8, cy8, v8, n8} : {z1, cy1, v1, n1};
            total++;
            if (e.kind == 1'b0) begin
                if ({gy, gc} !== {e.y, e.cout}) begin
                    bad++;
                    $display("FAIL %s y/cout: got %h/%b want %h/%b", e.name, gy, gc, e.y, e.cout);
                end
            end else if (gf !== e.fl) begin
                bad++;
                $display("FAIL %s flags zcvn: got %b want %b", e.name, gf, e.fl);
            end
        end
    end

    // Reference arithmetic for the sweep, done on plain integers.
    function automatic logic [12:0] model(input int w, input logic [2:0] op,
                                          input logic [7:0] av, input logic [7:0] bv,
                                          input logic cv);
        int m, msb, ai, bi, bn, s, yy, co, v;
        m   = (1 << w) - 1;
        msb = 1 << (w - 1);
        ai  = int'(av) & m;
        bi  = int'(bv) & m;
        bn  = ~bi & m;
        co  = 0;
        v   = 0;
        s   = 0;
        yy  = 0;
        case (op)
            3'd0: yy = ai & bi;
            3'd1: yy = ai | bi;
            3'd2: begin
                s  = ai + bi + int'(cv);
                yy = s & m;
                co = (s >> w) & 1;
                v  = int'(((ai & msb) == (bi & msb)) && ((yy & msb) != (ai & msb)));
            end
`ifdef INV_ALU_XOR_EN
            3'd3: yy = ai ^ bi;
`else
            3'd3: yy = 0;
`endif
            3'd4: yy = ai & bn;
            3'd5: yy = ai | bn;
            3'd6: begin
                s  = ai + bn + (cv ? 0 : 1);
                yy = s & m;
                co = (s >> w) & 1;
                v  = int'(((ai & msb) == (bn & msb)) && ((yy & msb) != (ai & msb)));
            end
            default: begin
                int d, vd;
                d  = (ai + bn + 1) & m;
                vd = int'(((ai & msb) == (bn & msb)) && ((d & msb) != (ai & msb)));
                yy = int'(((d & msb) != 0) ^ (vd != 0));
            end
        endcase
        model = {(yy == 0), co[0], v[0], ((yy & msb) != 0), co[0], yy[7:0]};
    endfunction

    task automatic issue_exp(input bit unit, input logic [2:0] op, input logic [7:0] av,
                             input logic [7:0] bv, input logic cv, input logic [7:0] ey,
                             input logic ec, input logic [3:0] ef, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        if (unit) begin
            op8 = op; a8 = av; b8 = bv; c8 = cv;
        end else begin
            op1 = op; a1 = av[0]; b1 = bv[0]; c1 = cv;
        end
        x.unit = unit; x.name = nm;
        x.due = cyc;     x.kind = 1'b0; x.y = ey; x.cout = ec; x.fl = 4'b0;
        sbq.push_back(x);
        x.due = cyc + 1; x.kind = 1'b1; x.fl = ef;
        sbq.push_back(x);
    endtask

    task automatic issue_model(input bit unit, input logic [2:0] op, input logic [7:0] av,
                               input logic [7:0] bv, input logic cv, input string nm);
        logic [12:0] r;
        r = model(unit ? 8 : 1, op, av, bv, cv);
        issue_exp(unit, op, av, bv, cv, r[7:0], r[8], r[12:9], nm);
    endtask

    initial begin
        exp_t x;
        logic [5:0] vv;
        // Reset held: result still combinational, flags stay clear across an edge.
        @(posedge clk);
        #1;
        op1 = 3'b010; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        x.unit = 1'b0; x.name = "reset"; x.y = 8'h01; x.cout = 1'b1; x.fl = 4'b0000;
        x.due = cyc;     x.kind = 1'b0; sbq.push_back(x);
        x.due = cyc;     x.kind = 1'b1; sbq.push_back(x);
        x.due = cyc + 1; x.kind = 1'b1; sbq.push_back(x);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;

        // Hand-computed 1-bit vectors.
        issue_exp(1'b0, 3'b000, 8'h1, 8'h0, 1'b0, 8'h00, 1'b0, 4'b1000, "and1_10");
        issue_exp(1'b0, 3'b001, 8'h0, 8'h1, 1'b0, 8'h01, 1'b0, 4'b0001, "or1_01");
        issue_exp(1'b0, 3'b110, 8'h0, 8'h1, 1'b0, 8'h01, 1'b0, 4'b0011, "sub1_010");
        issue_exp(1'b0, 3'b111, 8'h1, 8'h0, 1'b0, 8'h01, 1'b0, 4'b0001, "slt1_10");

        // Exhaustive 1-bit sweep.
        for (int i = 0; i < 64; i++) begin
            vv = 6'(i);
            issue_model(1'b0, vv[5:3], {7'b0, vv[2]}, {7'b0, vv[1]}, vv[0], $sformatf("sweep%0d", i));
        end

        // Hand-computed 8-bit vectors.
        issue_exp(1'b1, 3'b010, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 4'b0011, "add_ovf");
        issue_exp(1'b1, 3'b111, 8'h80, 8'h01, 1'b0, 8'h01, 1'b0, 4'b0000, "slt_neg_pos");
        issue_exp(1'b1, 3'b111, 8'h01, 8'h80, 1'b1, 8'h00, 1'b0, 4'b1000, "slt_pos_neg");
        issue_exp(1'b1, 3'b110, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 4'b0001, "sub_borrow");
        issue_exp(1'b1, 3'b110, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 4'b0110, "sub_ovf");
        issue_exp(1'b1, 3'b110, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 4'b0100, "sub_bin");
        issue_exp(1'b1, 3'b100, 8'hF0, 8'h3C, 1'b0, 8'hC0, 1'b0, 4'b0001, "andn");
        issue_exp(1'b1, 3'b101, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 4'b1000, "orn");
`ifdef INV_ALU_XOR_EN
        issue_exp(1'b1, 3'b011, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 4'b0001, "xor");
`else
        issue_exp(1'b1, 3'b011, 8'hF0, 8'h3C, 1'b0, 8'h00, 1'b0, 4'b1000, "xor_off");
`endif
        issue_exp(1'b1, 3'b010, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'b1100, "add_zero_carry");

        // Mid-cycle reset: flags clear at once, y keeps following the inputs.
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        x.unit = 1'b1; x.name = "midreset"; x.y = 8'h00; x.cout = 1'b1; x.fl = 4'b0000;
        x.due = cyc + 1; x.kind = 1'b0; sbq.push_back(x);
        x.due = cyc + 1; x.kind = 1'b1; sbq.push_back(x);
        @(negedge clk);
        #1 rst = 1'b1;
        issue_model(1'b1, 3'b010, 8'h40, 8'h40, 1'b1, "add_after_reset");

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_alu.md
# inv_alu

Parameterized MIPS-style ALU (ULA) datapath slice: combinational arithmetic/logic result plus a registered status-flag bank. It sits in the execute stage and is driven by the ALU-control decoder's 3-bit `ulaOp`. At `WIDTH = 1` it is a single chainable bit slice with explicit carry-in/carry-out.

## Interface
- `WIDTH`, default 1: operand and result width in bits; must be at least 1.
- `clk`  input  1: clock; flags sample on the rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `ulaOp`  input  3: operation select.
- `a`  input  WIDTH: operand A.
- `b`  input  WIDTH: operand B.
- `c`  input  1: carry-in for ADD, borrow-in for SUB.
- `y`  output  WIDTH: combinational result.
- `cout`  output  1: combinational carry-out of the adder; 0 for non-arithmetic ops.
- `zero_q`  output  1: registered flag, set when `y` is all zeros.
- `carry_q`  output  1: registered copy of `cout`.
- `ovf_q`  output  1: registered signed-overflow flag.
- `neg_q`  output  1: registered copy of `y[WIDTH-1]`.

## Operation
- `ulaOp` 000, AND: `y = a & b`; `cout` = 0.
- 001, OR: `y = a | b`; `cout` = 0.
- 010, ADD: `{cout, y} = a + b + c`.
- 011, XOR: `y = a ^ b` when `INV_ALU_XOR_EN` is defined; otherwise `y = 0`. `cout` = 0 in both cases.
- 100, AND-NOT: `y = a & ~b`; `cout` = 0.
- 101, OR-NOT: `y = a | ~b`; `cout` = 0.
- 110, SUB: `{cout, y} = a + ~b + !c`.
  - `c` = 1 means a borrow comes in.
  - `cout` = 1 means no borrow goes out.
- 111, SLT: `c` is ignored; compute `d = a + ~b + 1` (i.e. a − b).
  - `y[0]` = `d[WIDTH-1] ^ v`, where `v` is the signed overflow of `d`.
  - All upper bits of `y` are 0.
  - `cout` = 0.
- Signed overflow `v` is defined for ADD and SUB only: the operand signs (after B inversion) agree and the result sign differs. `v` = 0 for all other ops.
- At `WIDTH = 1`, signed values are 0 and −1.
- All inputs are 2-state. Any combination of `ulaOp` and data is legal.

## Timing
- `y` and `cout` are purely combinational.
  - Zero cycles of latency.
  - Valid within half a clock period of an input change.
  - Not affected by `rst`.
- Flags update on each rising edge of `clk` while `rst` = 1, loading from the current-cycle `y`, `cout` and `v`.
  - Flags therefore lag the result by one cycle.
- `rst` = 0 asynchronously clears `zero_q`, `carry_q`, `ovf_q` and `neg_q` to 0, immediately and independently of `clk`.
  - `zero_q` resets to 0, not 1.
- Reset deasserting coincident with a rising edge: that edge does not load; the first load is on the next rising edge.
- Reset asserting mid-cycle: flags clear immediately; `y` keeps following its inputs.

## Configuration
- `INV_ALU_XOR_EN`:
  - Defined: `ulaOp` = 011 performs XOR.
  - Undefined: 011 yields `y = 0`, `cout` = 0. The flags then load `zero_q` = 1, `neg_q` = 0, `carry_q` = 0, `ovf_q` = 0.
- No other behaviour changes with the macro.

## Test plan
- Reset: hold `rst` = 0 while driving ADD with `a` = 1, `b` = 1, `c` = 1 (`WIDTH` = 1).
  - All four flags read 0.
  - `y` = 1 and `cout` = 1 combinationally.
- Exhaustive 1-bit sweep: all 64 vectors of {`ulaOp`, `a`, `b`, `c`}, applied at posedge.
  - Check `y` at negedge against the Operation table.
  - Examples: AND 1,0 → 0; OR 0,1 → 1; SUB `a` = 0, `b` = 1, `c` = 0 → `y` = 1, `cout` = 0; SLT `a` = 1, `b` = 0 → `y` = 1.
- Flag latency (`WIDTH` = 8): ADD 0x7F + 0x01, `c` = 0.
  - Same cycle: `y` = 0x80.
  - After the next posedge: `ovf_q` = 1, `neg_q` = 1, `zero_q` = 0, `carry_q` = 0.
- Zero/carry (`WIDTH` = 8): ADD 0xFF + 0x01, `c` = 0 → `y` = 0x00, `cout` = 1; after the next edge `zero_q` = 1, `carry_q` = 1.
- SLT signed (`WIDTH` = 8):
  - `a` = 0x80, `b` = 0x01 → `y` = 0x01.
  - `a` = 0x01, `b` = 0x80 → `y` = 0x00.
- Macro check, `ulaOp` = 011, `a` = 0xF0, `b` = 0x3C:
  - With `INV_ALU_XOR_EN`: `y` = 0xCC.
  - Without it: `y` = 0x00 and `zero_q` = 1 after the next edge.
